// File: rtl/ex_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, grouped as one bus.
// The slave side is the stage itself; the master side drives ID/EX and observes EX/MEM.
interface ex_stage_if #(
  parameter int NB_DATA       = 32,
  parameter int NB_ADDR       = 5,
  parameter int NB_ALU_OPCODE = 4
);
  logic [NB_ALU_OPCODE-1:0] i_alu_opcode;
  logic                     i_second_ope_sa;
  logic                     i_first_ope_rt;
  logic                     i_use_imm;
  logic [NB_DATA-1:0]       i_rs_data;
  logic [NB_DATA-1:0]       i_rt_data;
  logic [NB_DATA-1:0]       i_imm;
  logic [NB_ADDR-1:0]       i_sa;
  logic [NB_ADDR-1:0]       i_dest_addr;
  logic                     i_reg_write;
  logic                     i_valid;
  logic                     i_stall;
  logic                     i_flush;

  logic [NB_DATA-1:0]       o_result;
  logic                     o_zero;
  logic                     o_overflow;
  logic [NB_DATA-1:0]       o_store_data;
  logic [NB_ADDR-1:0]       o_dest_addr;
  logic                     o_reg_write;
  logic                     o_valid;

  modport slave (
    input  i_alu_opcode, i_second_ope_sa, i_first_ope_rt, i_use_imm,
           i_rs_data, i_rt_data, i_imm, i_sa, i_dest_addr,
           i_reg_write, i_valid, i_stall, i_flush,
    output o_result, o_zero, o_overflow, o_store_data,
           o_dest_addr, o_reg_write, o_valid
  );

  modport master (
    output i_alu_opcode, i_second_ope_sa, i_first_ope_rt, i_use_imm,
           i_rs_data, i_rt_data, i_imm, i_sa, i_dest_addr,
           i_reg_write, i_valid, i_stall, i_flush,
    input  o_result, o_zero, o_overflow, o_store_data,
           o_dest_addr, o_reg_write, o_valid
  );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: operand select + combinational ALU into the EX/MEM register.
// Latency 1 cycle; i_stall holds EX/MEM, i_flush inserts a bubble and overrides stall.
module ex_stage #(
  parameter int NB_DATA       = 32,
  parameter int NB_ADDR       = 5,
  parameter int NB_ALU_OPCODE = 4
) (
  input  logic      i_clock,
  input  logic      i_reset,
  ex_stage_if.slave bus
);
  localparam logic [NB_ALU_OPCODE-1:0] OP_SLL  = 4'b0000;
  localparam logic [NB_ALU_OPCODE-1:0] OP_SRAV = 4'b0001;
  localparam logic [NB_ALU_OPCODE-1:0] OP_SRL  = 4'b0010;
  localparam logic [NB_ALU_OPCODE-1:0] OP_SRA  = 4'b0011;
  localparam logic [NB_ALU_OPCODE-1:0] OP_AND  = 4'b0100;
  localparam logic [NB_ALU_OPCODE-1:0] OP_OR   = 4'b0101;
  localparam logic [NB_ALU_OPCODE-1:0] OP_SRLV = 4'b0110;
  localparam logic [NB_ALU_OPCODE-1:0] OP_NOR  = 4'b0111;
  localparam logic [NB_ALU_OPCODE-1:0] OP_SLT  = 4'b1001;
  localparam logic [NB_ALU_OPCODE-1:0] OP_SLLV = 4'b1010;
  localparam logic [NB_ALU_OPCODE-1:0] OP_SUB  = 4'b1011;
  localparam logic [NB_ALU_OPCODE-1:0] OP_ADD  = 4'b1100;
  localparam logic [NB_ALU_OPCODE-1:0] OP_XOR  = 4'b1110;
  localparam logic [NB_ALU_OPCODE-1:0] OP_LUI  = 4'b1111;
  localparam int MSB = NB_DATA - 1;

  logic [NB_DATA-1:0] op_a, op_b, sum, diff, result_d;
  logic [NB_ADDR-1:0] shamt;
  logic               overflow_d;

  logic [NB_DATA-1:0] result_q, store_data_q;
  logic [NB_ADDR-1:0] dest_addr_q;
  logic               zero_q, overflow_q, reg_write_q, valid_q;

  always_comb begin
    op_a = (bus.i_first_ope_rt || bus.i_second_ope_sa) ? bus.i_rt_data : bus.i_rs_data;
    if (bus.i_second_ope_sa)     op_b = NB_DATA'(bus.i_sa);
    else if (bus.i_first_ope_rt) op_b = bus.i_rs_data;
    else if (bus.i_use_imm)      op_b = bus.i_imm;
    else                         op_b = bus.i_rt_data;

    shamt      = op_b[NB_ADDR-1:0];
    sum        = op_a + op_b;
    diff       = op_a - op_b;
    result_d   = '0;
    overflow_d = 1'b0;

    // Variable and fixed shifts differ only in where op_b came from.
    unique case (bus.i_alu_opcode)
      OP_ADD: begin
        result_d   = sum;
        overflow_d = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
      end
      OP_SUB: begin
        result_d   = diff;
        overflow_d = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
      end
      OP_SLL, OP_SLLV: result_d = op_a << shamt;
      OP_SRL, OP_SRLV: result_d = op_a >> shamt;
      OP_SRA, OP_SRAV: result_d = NB_DATA'($signed(op_a) >>> shamt);
      OP_AND:          result_d = op_a & op_b;
      OP_OR:           result_d = op_a | op_b;
      OP_XOR:          result_d = op_a ^ op_b;
      OP_NOR:          result_d = ~(op_a | op_b);
      OP_SLT:          result_d = {{(NB_DATA-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_LUI:          result_d = NB_DATA'({op_b[15:0], 16'h0000});
      default: begin
        result_d   = '0;
        overflow_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      result_q     <= '0;
      zero_q       <= 1'b0;
      overflow_q   <= 1'b0;
      store_data_q <= '0;
      dest_addr_q  <= '0;
      reg_write_q  <= 1'b0;
      valid_q      <= 1'b0;
    end else if (bus.i_flush) begin
      // Bubble: store data and destination are left as-is, they are don't-care once invalid.
      result_q    <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      reg_write_q <= 1'b0;
      valid_q     <= 1'b0;
    end else if (!bus.i_stall) begin
      result_q     <= result_d;
      zero_q       <= (result_d == '0);
      overflow_q   <= overflow_d;
      store_data_q <= bus.i_rt_data;
      dest_addr_q  <= bus.i_dest_addr;
      reg_write_q  <= bus.i_reg_write && bus.i_valid;
      valid_q      <= bus.i_valid;
    end
  end

  assign bus.o_result     = result_q;
  assign bus.o_zero       = zero_q;
  assign bus.o_overflow   = overflow_q;
  assign bus.o_store_data = store_data_q;
  assign bus.o_dest_addr  = dest_addr_q;
  assign bus.o_reg_write  = reg_write_q;
  assign bus.o_valid      = valid_q;
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline, directly downstream of alu_ctrl.
- Consumes alu_ctrl's ALU opcode and operand-select flags plus ID/EX register data, then selects operands, performs the ALU operation and captures the result in the EX/MEM pipeline register.
- Supports pipeline stall (hold) and flush (bubble insert). Output feeds the MEM stage and the branch-resolution logic.

Parameters:
- NB_DATA, 32, datapath width.
- NB_ADDR, 5, register-address width (clog2 of NB_DATA).
- NB_ALU_OPCODE, 4, ALU opcode width.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_alu_opcode  in  NB_ALU_OPCODE  operation from alu_ctrl.
- i_second_ope_sa  in  1  operand B is shamt (from alu_ctrl).
- i_first_ope_rt  in  1  operand A is rt; operand B is rs (from alu_ctrl).
- i_use_imm  in  1  operand B is i_imm (ignored when either flag above is set).
- i_rs_data  in  NB_DATA  rs register value.
- i_rt_data  in  NB_DATA  rt register value.
- i_imm  in  NB_DATA  sign-extended immediate.
- i_sa  in  NB_ADDR  shamt field.
- i_dest_addr  in  NB_ADDR  destination register.
- i_reg_write  in  1  instruction writes the register file.
- i_valid  in  1  ID/EX slot holds a real instruction.
- i_stall  in  1  hold the EX/MEM register.
- i_flush  in  1  insert a bubble into EX/MEM.
- o_result  out  NB_DATA  registered ALU result.
- o_zero  out  1  registered (result == 0).
- o_overflow  out  1  registered signed overflow (ADD/SUB only).
- o_store_data  out  NB_DATA  registered rt value.
- o_dest_addr  out  NB_ADDR  registered destination.
- o_reg_write  out  1  registered write enable, gated by valid.
- o_valid  out  1  EX/MEM slot valid.

Behaviour:
- Operand A = (i_first_ope_rt or i_second_ope_sa) ? i_rt_data : i_rs_data.
- Operand B priority: i_second_ope_sa → zero-extended i_sa; else i_first_ope_rt → i_rs_data; else i_use_imm → i_imm; else i_rt_data.
- ALU opcodes (fixed):
  - 1100 ADD, 1011 SUB
  - 0000 SLL, 0010 SRL, 0011 SRA (shift A by B[4:0])
  - 1010 SLLV, 0110 SRLV, 0001 SRAV (same shifts; B comes from rs)
  - 0100 AND, 0101 OR, 1110 XOR, 0111 NOR
  - 1001 SLT (signed, result 1 or 0)
  - 1111 LUI (B[15:0] << 16)
  - Any other code: result 0, overflow 0.
- Arithmetic: ADD/SUB wrap modulo 2^NB_DATA. Overflow is set when operand signs match (ADD) or differ (SUB) and the result sign differs from A. Shift amounts use only the low 5 bits. SRA/SRAV replicate A[31].
- ALU core is combinational. Latency is 1 cycle from the input sample edge to the registered outputs.
- Per-edge priority:
  1. i_reset: all outputs 0.
  2. i_flush: o_valid=0, o_reg_write=0, o_overflow=0, o_result=0, o_zero=0; other outputs hold.
  3. i_stall: every output holds its value.
  4. Otherwise capture: o_valid=i_valid, o_reg_write=i_reg_write&i_valid, plus all computed values.
- Flush together with stall → flush wins.
- Reset mid-stall clears everything; the first capture happens on the first edge after reset deasserts, with no stall.
- o_zero is derived from the captured result, never from a stale value.
- Invalid input (i_valid=0) still captures data but forces o_reg_write=0.

Test Plan:
- Reset asserted 2 cycles with random inputs → all outputs 0. Release with ADD, rs=5, rt=7, i_valid=1 → next edge o_result=12, o_zero=0, o_valid=1.
- SUB rs=0x7FFFFFFF, rt=0xFFFFFFFF → o_result=0x80000000, o_overflow=1. SUB rs=rt=9 → o_result=0, o_zero=1.
- SLL sa=4, rt=0x0000000F (flag sa=1) → 0x000000F0. SRAV rt=0x80000000, rs=0x21 (flag rt=1) → shift by 1 → 0xC0000000.
- SLT rs=0xFFFFFFFF, rt=1 → 1. LUI imm=0x00001234 → 0x12340000. Undefined opcode 1000 → 0.
- Capture ADD result 3, then i_stall=1 for 3 cycles with changing inputs → outputs stay 3. Raise i_flush together with stall → o_valid=0, o_reg_write=0.
- i_valid=0, i_reg_write=1 → o_reg_write=0, o_valid=0. Back-to-back instructions, no stall → each result appears exactly 1 cycle later, in order.
